// File: rtl/vga_mmio_display_if.sv
// CPU data-memory bus as seen by the display peripheral.
interface vga_mmio_display_if;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] read_data;

    // CPU side drives the request, peripheral returns load data.
    modport master (
        output address,
        output write_data,
        output mem_write,
        output mem_read,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_write,
        input  mem_read,
        output read_data
    );
endinterface

// File: rtl/vga_mmio_display.sv
// VGA raster generator with a memory-mapped colour/status register block.
// Colour writes land in stage registers and are copied to the active
// registers at vsync start, so a frame is always drawn with one colour set.
module vga_mmio_display #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000_0000_0000
) (
    input  logic               clock,
    input  logic               reset_n,
    vga_mmio_display_if.slave  bus,
    output logic               hsync,
    output logic               vsync,
    output logic               disp_enable,
    output logic [9:0]         pixel_x,
    output logic [9:0]         pixel_y,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue
);

    localparam int unsigned CW      = 10;
    localparam int unsigned CH      = 8;
    localparam int unsigned COLW    = 3 * CH;
    localparam int unsigned FCW     = 32;
    localparam int unsigned DW      = 64;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_EDGE     = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_EDGE     = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    // Last line before the sync pulse; the wrap out of it starts vsync.
    localparam logic [CW-1:0] V_PRE_SYNC = CW'(V_ACTIVE + V_FP - 1);

    localparam logic [1:0] OFF_BG     = 2'd0;
    localparam logic [1:0] OFF_FG     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_FCOUNT = 2'd3;

    logic [CW-1:0]   h_count_q, h_count_d;
    logic [CW-1:0]   v_count_q, v_count_d;
    logic [COLW-1:0] bg_stage_q, bg_stage_d;
    logic [COLW-1:0] fg_stage_q, fg_stage_d;
    logic [COLW-1:0] bg_active_q, bg_active_d;
    logic [COLW-1:0] fg_active_q, fg_active_d;
    logic [FCW-1:0]  frame_count_q, frame_count_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            de_q, de_d;
    logic [CW-1:0]   px_q, px_d;
    logic [CW-1:0]   py_q, py_d;
    logic [COLW-1:0] rgb_q, rgb_d;

    logic            bus_hit_c;
    logic [1:0]      bus_off_c;
    logic            h_wrap_c;
    logic            frame_latch_c;
    logic            visible_c;
    logic            border_c;
    logic            unused_wdata_c;

    // Colour registers only hold 24 bits; the rest of the store data is dropped.
    assign unused_wdata_c = ^bus.write_data[DW-1:COLW];

    // Register block decode: four word offsets at the base address.
    always_comb begin
        bus_hit_c = (bus.address[DW-1:2] == BASE_ADDR[DW-1:2]);
        bus_off_c = bus.address[1:0];
    end

    // Raster counters and the frame-boundary latch strobe.
    always_comb begin
        h_wrap_c  = (h_count_q == H_LAST);
        h_count_d = h_wrap_c ? '0 : h_count_q + CW'(1);
        v_count_d = v_count_q;
        if (h_wrap_c) begin
            v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + CW'(1);
        end
        frame_latch_c = h_wrap_c && (v_count_q == V_PRE_SYNC);
    end

    // Stage writes from the bus; stage-to-active copy and frame count at sync start.
    always_comb begin
        bg_stage_d    = bg_stage_q;
        fg_stage_d    = fg_stage_q;
        bg_active_d   = bg_active_q;
        fg_active_d   = fg_active_q;
        frame_count_d = frame_count_q;
        if (bus.mem_write && bus_hit_c) begin
            case (bus_off_c)
                OFF_BG:  bg_stage_d = bus.write_data[COLW-1:0];
                OFF_FG:  fg_stage_d = bus.write_data[COLW-1:0];
                default: ;
            endcase
        end
        // Copies the pre-write stage value, so a same-edge write waits a frame.
        if (frame_latch_c) begin
            bg_active_d   = bg_stage_q;
            fg_active_d   = fg_stage_q;
            frame_count_d = frame_count_q + FCW'(1);
        end
    end

    // Video outputs for the current counter position, registered one clock later.
    always_comb begin
        visible_c = (h_count_q < H_VIS_END) && (v_count_q < V_VIS_END);
        border_c  = (h_count_q == '0) || (h_count_q == H_EDGE) ||
                    (v_count_q == '0) || (v_count_q == V_EDGE);
        hsync_d   = !((h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END));
        vsync_d   = !((v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END));
        de_d      = visible_c;
        px_d      = h_count_q;
        py_d      = v_count_q;
        rgb_d     = '0;
        if (visible_c) begin
            rgb_d = border_c ? fg_active_q : bg_active_q;
        end
    end

    // Load data mux; status reflects the registered pins software can observe.
    always_comb begin
        bus.read_data = '0;
        if (bus.mem_read && bus_hit_c) begin
            case (bus_off_c)
                OFF_BG:     bus.read_data = DW'(bg_stage_q);
                OFF_FG:     bus.read_data = DW'(fg_stage_q);
                OFF_STATUS: bus.read_data = DW'({~vsync_q, de_q});
                default:    bus.read_data = DW'(frame_count_q);
            endcase
        end
    end

    // State and output registers; reset aborts the frame and drops staged colours.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count_q     <= '0;
            v_count_q     <= '0;
            bg_stage_q    <= '0;
            fg_stage_q    <= '0;
            bg_active_q   <= '0;
            fg_active_q   <= '0;
            frame_count_q <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            px_q          <= '0;
            py_q          <= '0;
            rgb_q         <= '0;
        end else begin
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            bg_stage_q    <= bg_stage_d;
            fg_stage_q    <= fg_stage_d;
            bg_active_q   <= bg_active_d;
            fg_active_q   <= fg_active_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            px_q          <= px_d;
            py_q          <= py_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign disp_enable = de_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign red         = rgb_q[3*CH-1:2*CH];
    assign green       = rgb_q[2*CH-1:CH];
    assign blue        = rgb_q[CH-1:0];

endmodule

// File: tb/tb_vga_mmio_display.sv
// Bench for vga_mmio_display on a reduced 14-clock x 7-line raster.
module tb_vga_mmio_display;

    localparam int unsigned HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam logic [63:0] BASE = 64'h0200_0000_0000_0000;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [23:0] rgb;
    } vid_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic        re;
        logic [63:0] exp_rd;
    } vec_t;

    logic       clock;
    logic       reset_n;
    logic       hsync, vsync, disp_enable;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] red, green, blue;

    vga_mmio_display_if bus();

    vga_mmio_display #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BASE_ADDR(BASE)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus),
        .hsync(hsync),
        .vsync(vsync),
        .disp_enable(disp_enable),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .red(red),
        .green(green),
        .blue(blue)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: edges since reset, stage/active colours, frame count,
    // and the video word the DUT should currently be presenting.
    vid_t        exp_q[$];
    int unsigned m_k;
    logic [23:0] m_bg_st, m_fg_st, m_bg_act, m_fg_act;
    logic [31:0] m_fc;
    vid_t        m_out;
    int          total;
    int          bad;
    vec_t        tbl[12];

    function automatic vid_t reset_vid();
        vid_t v;
        v    = '0;
        v.hs = 1'b1;
        v.vs = 1'b1;
        return v;
    endfunction

    function automatic vid_t dut_vid();
        vid_t v;
        v.hs  = hsync;
        v.vs  = vsync;
        v.de  = disp_enable;
        v.px  = pixel_x;
        v.py  = pixel_y;
        v.rgb = {red, green, blue};
        return v;
    endfunction

    // Expected registered output produced by raster position k (edges since reset).
    function automatic vid_t model_pix(input int unsigned k);
        int unsigned h, v;
        logic        border;
        vid_t        o;
        h      = k % HT;
        v      = (k / HT) % VT;
        o.hs   = !((h >= HA + HF) && (h < HA + HF + HS));
        o.vs   = !((v >= VA + VF) && (v < VA + VF + VS));
        o.de   = (h < HA) && (v < VA);
        o.px   = 10'(h);
        o.py   = 10'(v);
        border = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
        o.rgb  = !o.de ? 24'h0 : (border ? m_fg_act : m_bg_act);
        return o;
    endfunction

    function automatic logic [63:0] model_rd(input logic [63:0] a, input logic re);
        if (!re || (a[63:2] != BASE[63:2])) return 64'h0;
        case (a[1:0])
            2'd0:    return 64'(m_bg_st);
            2'd1:    return 64'(m_fg_st);
            2'd2:    return 64'({~m_out.vs, m_out.de});
            default: return 64'(m_fc);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, check load data, queue expected video, clock, check video.
    task automatic step(input logic [63:0] a, input logic [63:0] wd, input logic we,
                        input logic re, output logic [63:0] rd);
        int unsigned h, v;
        vid_t        e;
        bus.address    = a;
        bus.write_data = wd;
        bus.mem_write  = we;
        bus.mem_read   = re;
        #1;
        rd = bus.read_data;
        check("read_data", rd, model_rd(a, re));
        e = model_pix(m_k);
        exp_q.push_back(e);
        h = m_k % HT;
        v = (m_k / HT) % VT;
        if ((h == HT - 1) && (v == VA + VF - 1)) begin
            m_bg_act = m_bg_st;
            m_fg_act = m_fg_st;
            m_fc     = m_fc + 32'd1;
        end
        if (we && (a[63:2] == BASE[63:2])) begin
            if (a[1:0] == 2'd0) m_bg_st = wd[23:0];
            if (a[1:0] == 2'd1) m_fg_st = wd[23:0];
        end
        m_out = e;
        m_k++;
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check("video", 64'(dut_vid()), 64'(e));
    endtask

    task automatic idle();
        logic [63:0] d;
        step(64'h0, 64'h0, 1'b0, 1'b0, d);
    endtask

    task automatic run_to(input int unsigned h, input int unsigned v);
        int n = 0;
        do begin
            idle();
            n++;
        end while (!((m_out.px == 10'(h)) && (m_out.py == 10'(v))) && (n < 2 * HT * VT));
        if (n >= 2 * HT * VT) begin
            total++;
            bad++;
            $display("FAIL run_to: pixel (%0d,%0d) not reached in %0d cycles", h, v, n);
        end
    endtask

    task automatic wait_vs_low();
        int n = 0;
        do begin
            idle();
            n++;
        end while (m_out.vs && (n < 2 * HT * VT));
        if (n >= 2 * HT * VT) begin
            total++;
            bad++;
            $display("FAIL wait_vs_low: vsync pulse not reached in %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.address    = 64'h0;
        bus.write_data = 64'h0;
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("reset_video", 64'(dut_vid()), 64'(reset_vid()));
        bus.address  = BASE;
        bus.mem_read = 1'b1;
        #1;
        check("reset_bg_read", bus.read_data, 64'h0);
        bus.mem_read = 1'b0;
        m_k      = 0;
        m_bg_st  = '0;
        m_fg_st  = '0;
        m_bg_act = '0;
        m_fg_act = '0;
        m_fc     = '0;
        m_out    = reset_vid();
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        check("reset_hold", 64'(dut_vid()), 64'(reset_vid()));
        reset_n = 1'b1;
    endtask

    // After release: first pixel, then one full frame of sync/enable counts.
    task automatic first_frame();
        logic [63:0] rd;
        int          hs_lo, vs_lo, de_hi;
        hs_lo = 0;
        vs_lo = 0;
        de_hi = 0;
        step(BASE, 64'h0, 1'b0, 1'b1, rd);
        check("first_bg_read", rd, 64'h0);
        check("first_de", 64'(disp_enable), 64'h1);
        check("first_xy", 64'({pixel_x, pixel_y}), 64'h0);
        check("first_rgb", 64'({red, green, blue}), 64'h0);
        for (int i = 0; i < int'(HT * VT); i++) begin
            if (i != 0) idle();
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (disp_enable) de_hi++;
        end
        check("hsync_low_clocks", 64'(hs_lo), 64'd14);
        check("vsync_low_clocks", 64'(vs_lo), 64'd14);
        check("de_high_clocks", 64'(de_hi), 64'd32);
    endtask

    initial begin
        logic [63:0] rd;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        tbl[0]  = '{BASE,          64'h00FF00,              1'b1, 1'b0, 64'h0};
        tbl[1]  = '{BASE,          64'h0,                   1'b0, 1'b1, 64'h00FF00};
        tbl[2]  = '{BASE + 64'd4,  64'hABCDEF,              1'b1, 1'b0, 64'h0};
        tbl[3]  = '{BASE + 64'd4,  64'h0,                   1'b0, 1'b1, 64'h0};
        tbl[4]  = '{BASE,          64'h0,                   1'b0, 1'b1, 64'h00FF00};
        tbl[5]  = '{BASE + 64'd2,  64'h3,                   1'b1, 1'b0, 64'h0};
        tbl[6]  = '{BASE + 64'd3,  64'hFFFF,                1'b1, 1'b0, 64'h0};
        tbl[7]  = '{BASE + 64'd3,  64'h0,                   1'b0, 1'b1, 64'd3};
        tbl[8]  = '{BASE + 64'd1,  64'hFFFF_FFFF_FFAB_CDEF, 1'b1, 1'b0, 64'h0};
        tbl[9]  = '{BASE + 64'd1,  64'h0,                   1'b0, 1'b1, 64'hABCDEF};
        tbl[10] = '{BASE,          64'h0,                   1'b0, 1'b0, 64'h0};
        tbl[11] = '{BASE - 64'd1,  64'h0,                   1'b0, 1'b1, 64'h0};

        do_reset();
        first_frame();

        // Two more frames, then FRAME_COUNT should read 3.
        for (int i = 0; i < int'(2 * HT * VT); i++) idle();
        step(BASE + 64'd3, 64'h0, 1'b0, 1'b1, rd);
        check("frame_count_3", rd, 64'd3);

        // Register access vectors.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].re, rd);
            if (tbl[i].re) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
        end

        // Green background only appears after the next sync-start latch.
        run_to(3, 2);
        check("bg_before_latch", 64'({red, green, blue}), 64'h0);
        run_to(3, 2);
        check("bg_green_after_latch", 64'(green), 64'hFF);
        check("bg_green_rgb", 64'({red, green, blue}), 64'h00FF00);

        // Border uses FG, interior uses BG.
        step(BASE + 64'd1, 64'h0000FF, 1'b1, 1'b0, rd);
        step(BASE,         64'h112233, 1'b1, 1'b0, rd);
        run_to(0, 1);
        check("border_left", 64'({red, green, blue}), 64'h0000FF);
        run_to(3, 2);
        check("interior_red", 64'(red), 64'h11);
        check("interior_green", 64'(green), 64'h22);
        check("interior_blue", 64'(blue), 64'h33);
        run_to(7, 3);
        check("border_corner", 64'({red, green, blue}), 64'h0000FF);

        // Write landing on the latch edge takes effect one frame late.
        step(BASE, 64'h000001, 1'b1, 1'b0, rd);
        run_to(12, 4);
        step(BASE, 64'h000002, 1'b1, 1'b0, rd);
        step(BASE, 64'h0, 1'b0, 1'b1, rd);
        check("latch_edge_stage", rd, 64'h000002);
        run_to(3, 2);
        check("latch_edge_frame1", 64'({red, green, blue}), 64'h000001);
        run_to(3, 2);
        check("latch_edge_frame2", 64'({red, green, blue}), 64'h000002);

        // Status polling during sync and during visible area.
        wait_vs_low();
        step(BASE + 64'd2, 64'h0, 1'b0, 1'b1, rd);
        check("status_sync", rd, 64'd2);
        run_to(3, 2);
        step(BASE + 64'd2, 64'h0, 1'b0, 1'b1, rd);
        check("status_visible", rd, 64'd1);

        // Reset in mid-frame: colours and count cleared, raster restarts.
        for (int i = 0; i < 20; i++) idle();
        do_reset();
        step(BASE, 64'h0, 1'b0, 1'b1, rd);
        check("rst2_bg_read", rd, 64'h0);
        check("rst2_de", 64'(disp_enable), 64'h1);
        check("rst2_xy", 64'({pixel_x, pixel_y}), 64'h0);
        run_to(3, 2);
        check("rst2_interior", 64'({red, green, blue}), 64'h0);
        step(BASE + 64'd3, 64'h0, 1'b0, 1'b1, rd);
        check("rst2_frame_count", rd, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
